prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: program buffer word count, power of two, 4..64.
REQ-002 Parameter AW, default 4: address width, equal to log2(DEPTH).
REQ-003 CLKb  in  1  debounced processor clock; all state updates occur on its negative edge.
REQ-004 CLR  in  1  reset, asynchronous, active-high.
REQ-005 LD_EN  in  1  buffer write strobe.
REQ-006 LD_ADDR  in  AW  buffer write address.
REQ-007 LD_DATA  in  10  buffer write data.
REQ-008 START  in  1  begin execution at address 0.
REQ-009 EXT_REQ  in  1  controller external-data request (Ext).
REQ-010 DONE  in  1  controller instruction-complete (Clr).
REQ-011 WORD_OUT  out  10  word presented to processor data input.
REQ-012 WORD_VALID  out  1  WORD_OUT holds a live instruction or operand.
REQ-013 PC  out  AW  address of the current instruction.
REQ-014 BUSY  out  1  high in every state except IDLE and HALTED.
REQ-015 HALT  out  1  high in state HALTED.

Function
REQ-016 States SHALL be IDLE, FETCH, ISSUE, WAIT, HALTED.
REQ-017 IDLE: START=1 -> FETCH with PC=0; all other inputs except LD_EN are ignored.
REQ-018 FETCH: word mem[PC] with bits[9:8]=01 -> HALTED; otherwise -> ISSUE.
REQ-019 ISSUE: WORD_OUT=mem[PC] and WORD_VALID=1 for exactly one cycle, then -> WAIT.
REQ-020 WAIT, ld instruction (bits[9:8]=00, bits[3:0]=0000): while EXT_REQ=1, WORD_OUT=mem[PC+1] and WORD_VALID=1.
REQ-021 WAIT, any other instruction: WORD_VALID=0 and WORD_OUT=0.
REQ-022 WAIT with DONE=1 -> FETCH; PC advances by 2 for ld and by 1 for all other instructions.
REQ-023 PC arithmetic is modulo DEPTH: an ld at DEPTH-1 takes its operand from address 0, and PC wraps to 1.
REQ-024 DONE is ignored outside WAIT; EXT_REQ is ignored outside WAIT and for non-ld instructions.
REQ-025 START is ignored while BUSY=1; START in HALTED -> FETCH with PC=0.
REQ-026 LD_EN writes mem[LD_ADDR]=LD_DATA only in IDLE or HALTED; LD_EN is ignored while BUSY=1.
REQ-027 When LD_EN and START occur in the same cycle in IDLE, the write SHALL complete and FETCH SHALL read the written value.
REQ-028 Latency: START to first WORD_VALID is 2 cycles; DONE to next WORD_VALID is 2 cycles.

Reset
REQ-029 CLR=1 SHALL immediately force IDLE, PC=0, WORD_OUT=0, WORD_VALID=0, BUSY=0, HALT=0.
REQ-030 Buffer contents SHALL be preserved through CLR.
REQ-031 CLR asserted mid-instruction SHALL abandon the instruction with no PC advance; the next START restarts at address 0.

Configuration
REQ-032 Macro SEQ_SINGLE_STEP_EN, when defined, SHALL add input STEP (1 bit).
REQ-033 With SEQ_SINGLE_STEP_EN defined, FETCH SHALL wait for STEP=1 before evaluating the word; START still leaves IDLE or HALTED.
REQ-034 Without SEQ_SINGLE_STEP_EN, STEP is absent and FETCH evaluates in the cycle it is entered.

Verification
REQ-035 Load mem[0]=0x000 (ld R0), mem[1]=0x005, mem[2]=0x100 (halt); START; EXT_REQ=1 in WAIT -> WORD_OUT=0x000 then 0x005; DONE -> HALT=1, PC=2.
REQ-036 Load mem[0]=0x212 (addi R0,0x12), mem[1]=0x100; START; DONE in cycle 5 -> PC=1, then HALT=1; WORD_VALID pulses exactly once.
REQ-037 DEPTH=16, mem[15]=0x000, mem[0]=0x3FF; start with PC reaching 15 -> EXT_REQ yields WORD_OUT=0x3FF; after DONE, PC=1.
REQ-038 While BUSY: LD_EN to addr 3 with 0x0AA -> mem[3] unchanged; a second START is ignored; DONE asserted in ISSUE is ignored.
REQ-039 CLR in WAIT -> all outputs reach reset values without a clock edge; the next START gives WORD_OUT=mem[0].
REQ-040 With SEQ_SINGLE_STEP_EN defined: no STEP -> remains in FETCH with WORD_VALID=0; a single STEP pulse -> exactly one instruction is issued.

Source files
------------

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Small program buffer plus sequencer that feeds a simple processor one
// instruction (and, for ld, one operand) at a time. The buffer is loaded while
// the sequencer is idle or halted. START begins execution at address 0, and
// the controller hands control back with DONE. A word with bits[9:8]=01 halts
// the sequencer. All state changes happen on the falling edge of CLKb.
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add the STEP input. With the
// macro defined, FETCH holds until STEP=1 before it evaluates the word.
//
// Parameters
//   DEPTH      program buffer word count (power of two, 4..64)
//   AW         address width, log2(DEPTH)
// Ports
//   CLKb       in   processor clock (state updates on its negative edge)
//   CLR        in   asynchronous active-high reset (buffer contents kept)
//   STEP       in   single-step advance (only with SEQ_SINGLE_STEP_EN)
//   LD_EN      in   buffer write strobe (honoured in IDLE/HALTED only)
//   LD_ADDR    in   buffer write address
//   LD_DATA    in   buffer write data
//   START      in   begin execution at address 0 (from IDLE or HALTED)
//   EXT_REQ    in   controller request for the ld operand
//   DONE       in   controller instruction-complete
//   WORD_OUT   out  instruction/operand word presented to the processor
//   WORD_VALID out  WORD_OUT holds a live word
//   PC         out  address of the current instruction
//   BUSY       out  sequencer is in FETCH, ISSUE or WAIT
//   HALT       out  sequencer is in HALTED
// -----------------------------------------------------------------------------
module prog_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          CLKb,
   input  logic          CLR,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic          STEP,
`endif
   input  logic          LD_EN,
   input  logic [AW-1:0] LD_ADDR,
   input  logic [9:0]    LD_DATA,
   input  logic          START,
   input  logic          EXT_REQ,
   input  logic          DONE,
   output logic [9:0]    WORD_OUT,
   output logic          WORD_VALID,
   output logic [AW-1:0] PC,
   output logic          BUSY,
   output logic          HALT
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   logic [9:0]    mem_r [DEPTH];
   state_t        state_r, state_next_s;
   logic [AW-1:0] pc_r, pc_next_s;
   logic [9:0]    word_r, word_next_s;
   logic          valid_r, valid_next_s;
   logic          busy_r, busy_next_s;
   logic          halt_r, halt_next_s;

   logic [9:0]    cur_word_s;
   logic [AW-1:0] op_addr_s;
   logic [9:0]    op_word_s;
   logic          is_ld_s;
   logic          is_halt_s;
   logic          step_ok_s;
   logic          wr_en_s;

   // The buffer cannot change while BUSY, so the current word is read
   // straight from it instead of being copied into an instruction register.
   assign cur_word_s = mem_r[pc_r];
   // AW-bit addition wraps modulo DEPTH, so an ld at DEPTH-1 reads address 0.
   assign op_addr_s  = pc_r + AW'(1);
   assign op_word_s  = mem_r[op_addr_s];
   assign is_ld_s    = (cur_word_s[9:8] == 2'b00) && (cur_word_s[3:0] == 4'b0000);
   assign is_halt_s  = (cur_word_s[9:8] == 2'b01);
   assign wr_en_s    = LD_EN && ((state_r == ST_IDLE) || (state_r == ST_HALTED));

`ifdef SEQ_SINGLE_STEP_EN
   assign step_ok_s = STEP;
`else
   assign step_ok_s = 1'b1;
`endif

   // Program buffer write port; no reset so contents survive CLR.
   always_ff @(negedge CLKb) begin
      if (wr_en_s) begin
         mem_r[LD_ADDR] <= LD_DATA;
      end
   end

   // Next-state, next-PC and next-output decode. Outputs are computed here
   // for the state being entered so they can be registered alongside it.
   always_comb begin
      state_next_s = state_r;
      pc_next_s    = pc_r;
      word_next_s  = 10'd0;
      valid_next_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_HALTED: begin
            if (START) begin
               state_next_s = ST_FETCH;
               pc_next_s    = {AW{1'b0}};
            end else begin
               state_next_s = state_r;
            end
         end
         ST_FETCH: begin
            if (!step_ok_s) begin
               state_next_s = ST_FETCH;
            end else if (is_halt_s) begin
               state_next_s = ST_HALTED;
            end else begin
               state_next_s = ST_ISSUE;
               word_next_s  = cur_word_s;
               valid_next_s = 1'b1;
            end
         end
         ST_ISSUE: begin
            // DONE is deliberately not looked at here.
            state_next_s = ST_WAIT;
            if (is_ld_s && EXT_REQ) begin
               word_next_s  = op_word_s;
               valid_next_s = 1'b1;
            end else begin
               word_next_s  = 10'd0;
               valid_next_s = 1'b0;
            end
         end
         ST_WAIT: begin
            if (DONE) begin
               state_next_s = ST_FETCH;
               pc_next_s    = is_ld_s ? (pc_r + AW'(2)) : (pc_r + AW'(1));
            end else if (is_ld_s && EXT_REQ) begin
               state_next_s = ST_WAIT;
               word_next_s  = op_word_s;
               valid_next_s = 1'b1;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            pc_next_s    = {AW{1'b0}};
         end
      endcase
   end

   assign busy_next_s = (state_next_s == ST_FETCH) || (state_next_s == ST_ISSUE) ||
                        (state_next_s == ST_WAIT);
   assign halt_next_s = (state_next_s == ST_HALTED);

   // State, PC and registered outputs; CLR clears them without a clock edge.
   always_ff @(negedge CLKb or posedge CLR) begin
      if (CLR) begin
         state_r <= ST_IDLE;
         pc_r    <= {AW{1'b0}};
         word_r  <= 10'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         halt_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         pc_r    <= pc_next_s;
         word_r  <= word_next_s;
         valid_r <= valid_next_s;
         busy_r  <= busy_next_s;
         halt_r  <= halt_next_s;
      end
   end

   assign WORD_OUT   = word_r;
   assign WORD_VALID = valid_r;
   assign PC         = pc_r;
   assign BUSY       = busy_r;
   assign HALT       = halt_r;

endmodule
